// File: rtl/uart_reg_decoder.sv
// Frames the UART RX byte stream (SYNC, ADDR, DHI, DLO, CSUM) into 16-bit register writes,
// with checksum, address and inter-byte timeout protection plus a DAC-bank side write.
module uart_reg_decoder #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [6:0]  DAC_ADDR    = 7'h7F,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        reg_ready,
    output logic [6:0]  reg_address,
    output logic [15:0] reg_data,
    output logic        dac_we,
    output logic [2:0]  dac_sel,
    output logic [11:0] dac_data,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    dhi_q, dhi_d;
    logic [7:0]    dlo_q, dlo_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          commit, err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            addr_q  <= '0;
            dhi_q   <= '0;
            dlo_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dhi_q   <= dhi_d;
            dlo_q   <= dlo_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        commit  = 1'b0;
        err     = 1'b0;

        // Expiry is the idle cycle that would bring the count to TIMEOUT_CYC;
        // a byte in that cycle clears the count instead.
        if (state_q == S_HUNT || rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            tmo_d   = '0;
            err     = 1'b1;
            state_d = S_HUNT;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (rx_valid) begin
            case (state_q)
                S_HUNT: begin
                    if (rx_data == SYNC_BYTE) state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (rx_data[7]) begin
                        err     = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        addr_d  = rx_data[6:0];
                        csum_d  = rx_data;
                        state_d = S_DHI;
                    end
                end
                S_DHI: begin
                    dhi_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_DLO;
                end
                S_DLO: begin
                    dlo_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_data == csum_q) commit = 1'b1;
                    else                   err    = 1'b1;
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    // DAC fields only follow commits aimed at the DAC bank; other writes leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ready   <= 1'b0;
            reg_address <= '0;
            reg_data    <= '0;
            dac_we      <= 1'b0;
            dac_sel     <= '0;
            dac_data    <= '0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            reg_ready <= commit;
            frame_err <= err;
            dac_we    <= commit && (addr_q == DAC_ADDR);
            if (commit) begin
                reg_address <= addr_q;
                reg_data    <= {dhi_q, dlo_q};
                if (addr_q == DAC_ADDR) begin
                    dac_sel  <= dhi_q[6:4];
                    dac_data <= {dhi_q[3:0], dlo_q};
                end
            end
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_reg_decoder.sv
// Directed bench for uart_reg_decoder: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_uart_reg_decoder;

    localparam int T = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reg_ready;
    logic [6:0]  reg_address;
    logic [15:0] reg_data;
    logic        dac_we;
    logic [2:0]  dac_sel;
    logic [11:0] dac_data;
    logic        frame_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    uart_reg_decoder dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .reg_ready(reg_ready), .reg_address(reg_address), .reg_data(reg_data),
        .dac_we(dac_we), .dac_sel(dac_sel), .dac_data(dac_data),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: collects the bytes after a sync and judges the frame once complete.
    bit          in_frame;
    logic [7:0]  fq[$];
    int          idle;
    logic        m_ready, m_err, m_we;
    logic [6:0]  m_addr;
    logic [15:0] m_data;
    logic [2:0]  m_sel;
    logic [11:0] m_dac;
    logic [7:0]  m_cnt;

    task automatic model_reset();
        in_frame = 0; fq.delete(); idle = 0;
        m_ready = 0; m_err = 0; m_we = 0;
        m_addr = '0; m_data = '0; m_sel = '0; m_dac = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        m_ready = 0; m_err = 0; m_we = 0;
        if (!in_frame) begin
            idle = 0;
            if (rx_valid && rx_data == 8'hA5) begin in_frame = 1; fq.delete(); end
        end else if (rx_valid) begin
            idle = 0;
            fq.push_back(rx_data);
            if (fq.size() == 1 && fq[0][7]) begin
                m_err = 1; in_frame = 0;
            end else if (fq.size() == 4) begin
                in_frame = 0;
                if ((fq[0] ^ fq[1] ^ fq[2]) == fq[3]) begin
                    m_ready = 1;
                    m_addr  = fq[0][6:0];
                    m_data  = {fq[1], fq[2]};
                    if (m_addr == 7'h7F) begin
                        m_we = 1; m_sel = m_data[14:12]; m_dac = m_data[11:0];
                    end
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            idle++;
            if (idle == T) begin m_err = 1; in_frame = 0; idle = 0; end
        end
        if (m_err && m_cnt != 8'hFF) m_cnt++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({reg_ready, frame_err, reg_address, reg_data, dac_we, dac_sel, dac_data, err_count} !==
                {m_ready, m_err, m_addr, m_data, m_we, m_sel, m_dac, m_cnt}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got rdy=%b err=%b a=%h d=%h we=%b sel=%h dac=%h cnt=%0d required rdy=%b err=%b a=%h d=%h we=%b sel=%h dac=%h cnt=%0d",
                         $time, reg_ready, frame_err, reg_address, reg_data, dac_we, dac_sel, dac_data, err_count,
                         m_ready, m_err, m_addr, m_data, m_we, m_sel, m_dac, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        send(8'hA5); send(a); send(h); send(l); send(c);
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_outputs", {reg_ready, frame_err, dac_we, reg_address, reg_data, dac_sel, dac_data}, 32'h0);
        chk("reset_err_count", err_count, 0);

        // 1: DAC write
        frame(8'h7F, 8'h12, 8'h34, 8'h59); idle_cyc();
        chk("t1_ready", reg_ready, 1); chk("t1_addr", reg_address, 7'h7F);
        chk("t1_data", reg_data, 16'h1234); chk("t1_we", dac_we, 1);
        chk("t1_sel", dac_sel, 1); chk("t1_dac", dac_data, 12'h234);
        idle_cyc();
        chk("t1_ready_pulse", reg_ready, 0);

        // 2: non-DAC write leaves DAC fields alone
        frame(8'h05, 8'hAB, 8'hCD, 8'h63); idle_cyc();
        chk("t2_ready", reg_ready, 1); chk("t2_addr", reg_address, 7'h05);
        chk("t2_data", reg_data, 16'hABCD); chk("t2_we", dac_we, 0);
        chk("t2_dac_keep", {dac_sel, dac_data}, {3'd1, 12'h234});

        // 3: bad checksum
        frame(8'h7F, 8'h12, 8'h34, 8'h58); idle_cyc();
        chk("t3_err", frame_err, 1); chk("t3_cnt", err_count, 1);
        chk("t3_ready", reg_ready, 0); chk("t3_keep", reg_data, 16'hABCD);
        idle_cyc();
        chk("t3_err_pulse", frame_err, 0);

        // 4: timeout exactly at T idle cycles, then a clean frame
        send(8'hA5); send(8'h7F); send(8'h12);
        repeat (T) idle_cyc();
        chk("t4_no_early_timeout", frame_err, 0);
        idle_cyc();
        chk("t4_timeout_err", frame_err, 1); chk("t4_cnt", err_count, 2);
        frame(8'h7F, 8'h0A, 8'hBC, 8'hC9); idle_cyc();
        chk("t4_ready", reg_ready, 1); chk("t4_data", reg_data, 16'h0ABC);
        chk("t4_dac", {dac_sel, dac_data}, {3'd0, 12'hABC});

        // byte arriving in the would-be expiry cycle is taken, no timeout
        send(8'hA5); send(8'h7F); send(8'h12);
        repeat (T - 1) idle_cyc();
        send(8'h34); send(8'h59); idle_cyc();
        chk("t4b_ready", reg_ready, 1); chk("t4b_cnt", err_count, 2);

        // sync value as payload and bit15 carried through
        frame(8'h7F, 8'hA5, 8'hA5, 8'h7F); idle_cyc();
        chk("sync_payload_data", reg_data, 16'hA5A5);
        chk("sync_payload_dac", {dac_sel, dac_data}, {3'd2, 12'h5A5});
        frame(8'h7F, 8'h81, 8'h23, 8'hDD); idle_cyc();
        chk("bit15_data", reg_data, 16'h8123);
        chk("bit15_dac", {dac_sel, dac_data}, {3'd0, 12'h123});

        // 5: address bit7, junk in HUNT, back-to-back frames, saturation
        send(8'hA5); send(8'h85); idle_cyc();
        chk("t5_addr_err", frame_err, 1); chk("t5_cnt", err_count, 3);
        send(8'h00); send(8'hFF); send(8'h11); idle_cyc();
        chk("t5_junk", {frame_err, reg_ready}, 0); chk("t5_junk_cnt", err_count, 3);
        frame(8'h05, 8'hAB, 8'hCD, 8'h63);
        frame(8'h7F, 8'h12, 8'h34, 8'h59); idle_cyc();
        chk("b2b_ready", reg_ready, 1); chk("b2b_data", reg_data, 16'h1234);
        for (int i = 0; i < 300; i++) begin send(8'hA5); send(8'h85); end
        idle_cyc(); idle_cyc();
        chk("t5_saturate", err_count, 255);

        // 6: async reset mid-frame
        send(8'hA5); send(8'h7F); send(8'h12); idle_cyc();
        rst_n = 1'b0; #1;
        chk("t6_reset_outputs", {reg_address, reg_data, dac_sel, dac_data}, 38'h0);
        chk("t6_reset_cnt", err_count, 0);
        idle_cyc(); idle_cyc();
        rst_n = 1'b1;
        send(8'h34); send(8'h59); idle_cyc();
        chk("t6_stale_ignored", {reg_ready, frame_err, reg_data}, 0);
        frame(8'h7F, 8'h12, 8'h34, 8'h59); idle_cyc();
        chk("t6_ready", reg_ready, 1); chk("t6_data", reg_data, 16'h1234);
        idle_cyc(); idle_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
